// File: rtl/qsic_pkg.sv
// Shared QSIC definitions: slave FSM states, I/O-page address width and synchronizer depth.
package qsic_pkg;

    localparam int IOPAGE_BITS = 13;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        NOTME,
        WAITCMD,
        RD,
        WR,
        RDEND,
        WREND
    } qs_state_t;

endpackage

// File: rtl/sync2.sv
// Multi-flop synchronizer for an asynchronous bus strobe, cleared by the async reset.
module sync2
    import qsic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/qslave_regs.sv
// QBUS programmed-I/O slave: decodes I/O-page DATI/DATO(B)/DATIO cycles onto a simple
// register port and returns RPLY once the register file reports ready.
module qslave_regs
    import qsic_pkg::*;
#(
    parameter logic [IOPAGE_BITS-1:0] BASE_ADDR = 13'o17720,
    parameter int                     NREGS     = 8,
    parameter int                     RDY_TMO   = 16
) (
    input  logic        qclk,
    input  logic        reset_n,
    input  logic        RSYNC,
    input  logic        RDIN,
    input  logic        RDOUT,
    input  logic        RWTBT,
    input  logic        RBS7,
    input  logic        RINIT,
    input  logic [21:0] RDAL,
    output logic        TRPLY,
    output logic [15:0] TDAL,
    output logic        assert_data,
    output logic [5:0]  reg_addr,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic [1:0]  reg_be,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    input  logic        reg_ready,
    output logic        selected
);

    localparam int                     TMO_W     = $clog2(RDY_TMO + 1);
    localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(RDY_TMO - 1);
    localparam logic [IOPAGE_BITS-2:0] BASE_WORD = BASE_ADDR[IOPAGE_BITS-1:1];
    localparam logic [IOPAGE_BITS-2:0] NREGS_W   = (IOPAGE_BITS-1)'(NREGS);

    qs_state_t               state;
    logic                    sync_q;
    logic                    s_din;
    logic                    s_dout;
    logic                    s_init;
    logic                    byte_hi;
    logic [TMO_W-1:0]        tmo;
    logic [IOPAGE_BITS-2:0]  word_sel;
    logic [IOPAGE_BITS-2:0]  word_off;
    logic                    addr_hit;
    logic                    unused_rdal;

    sync2 u_sync_din  (.clk(qclk), .rst_n(reset_n), .d(RDIN),  .q(s_din));
    sync2 u_sync_dout (.clk(qclk), .rst_n(reset_n), .d(RDOUT), .q(s_dout));
    sync2 u_sync_init (.clk(qclk), .rst_n(reset_n), .d(RINIT), .q(s_init));

    // SYNC needs only one flop: the address it qualifies is held well past the edge.
    always_ff @(posedge qclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= RSYNC;
        end
    end

    // BS7 already qualifies the I/O page, so DAL bits above the page offset are don't-care.
    assign word_sel    = RDAL[IOPAGE_BITS-1:1];
    assign word_off    = word_sel - BASE_WORD;
    assign addr_hit    = RBS7 && (word_sel >= BASE_WORD) && (word_off < NREGS_W);
    assign unused_rdal = ^RDAL[21:16];

    always_ff @(posedge qclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            TRPLY       <= 1'b0;
            TDAL        <= '0;
            assert_data <= 1'b0;
            reg_addr    <= '0;
            reg_rd      <= 1'b0;
            reg_wr      <= 1'b0;
            reg_be      <= '0;
            reg_wdata   <= '0;
            selected    <= 1'b0;
            byte_hi     <= 1'b0;
            tmo         <= '0;
        end else if (s_init) begin
            state       <= IDLE;
            TRPLY       <= 1'b0;
            TDAL        <= '0;
            assert_data <= 1'b0;
            reg_addr    <= '0;
            reg_rd      <= 1'b0;
            reg_wr      <= 1'b0;
            reg_be      <= '0;
            reg_wdata   <= '0;
            selected    <= 1'b0;
            byte_hi     <= 1'b0;
            tmo         <= '0;
        end else begin
            reg_rd <= 1'b0;
            reg_wr <= 1'b0;
            case (state)
                IDLE: begin
                    selected    <= 1'b0;
                    TRPLY       <= 1'b0;
                    assert_data <= 1'b0;
                    if (sync_q) begin
                        if (addr_hit) begin
                            state    <= WAITCMD;
                            selected <= 1'b1;
                            reg_addr <= word_off[5:0];
                            byte_hi  <= RDAL[0];
                        end else begin
                            state <= NOTME;
                        end
                    end
                end
                NOTME: begin
                    if (!sync_q) state <= IDLE;
                end
                // DIN wins over DOUT when both appear: a read has no side effects.
                WAITCMD: begin
                    tmo <= '0;
                    if (s_din) begin
                        state  <= RD;
                        reg_rd <= 1'b1;
                    end else if (s_dout) begin
                        state     <= WR;
                        reg_wr    <= 1'b1;
                        reg_wdata <= RDAL[15:0];
                        reg_be    <= RWTBT ? (byte_hi ? 2'b10 : 2'b01) : 2'b11;
                    end else if (!sync_q) begin
                        state <= IDLE;
                    end
                end
                RD: begin
                    if (!sync_q) begin
                        state <= IDLE;
                    end else if (reg_ready) begin
                        TDAL        <= reg_rdata;
                        assert_data <= 1'b1;
                        TRPLY       <= 1'b1;
                        state       <= RDEND;
                    end else if (tmo == TMO_LAST) begin
                        state <= NOTME;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                WR: begin
                    if (!sync_q) begin
                        state <= IDLE;
                    end else if (reg_ready) begin
                        TRPLY <= 1'b1;
                        state <= WREND;
                    end else if (tmo == TMO_LAST) begin
                        state <= NOTME;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                RDEND: begin
                    if (!sync_q || !s_din) begin
                        TRPLY       <= 1'b0;
                        assert_data <= 1'b0;
                        state       <= sync_q ? WAITCMD : IDLE;
                    end
                end
                WREND: begin
                    if (!sync_q || !s_dout) begin
                        TRPLY <= 1'b0;
                        state <= sync_q ? WAITCMD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qslave_regs.sv
// Bench for qslave_regs: bus-master tasks, a behavioural register file and a byte-level model.
module tb_qslave_regs;

    localparam int NREGS   = 8;
    localparam int RDY_TMO = 16;
    localparam int BASE    = 'o17720;

    logic        qclk = 1'b0;
    logic        reset_n;
    logic        RSYNC, RDIN, RDOUT, RWTBT, RBS7, RINIT;
    logic [21:0] RDAL;
    logic        TRPLY;
    logic [15:0] TDAL;
    logic        assert_data;
    logic [5:0]  reg_addr;
    logic        reg_rd, reg_wr;
    logic [1:0]  reg_be;
    logic [15:0] reg_wdata, reg_rdata;
    logic        reg_ready;
    logic        selected;

    always #25 qclk = ~qclk;

    qslave_regs #(
        .BASE_ADDR(13'o17720),
        .NREGS(NREGS),
        .RDY_TMO(RDY_TMO)
    ) dut (
        .qclk(qclk), .reset_n(reset_n), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
        .RWTBT(RWTBT), .RBS7(RBS7), .RINIT(RINIT), .RDAL(RDAL), .TRPLY(TRPLY), .TDAL(TDAL),
        .assert_data(assert_data), .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .reg_be(reg_be), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
        .selected(selected)
    );

    // Register file seen by the DUT, plus strobe/selection bookkeeping.
    logic [15:0] regfile [64] = '{default: 16'h0};
    int          rd_cnt = 0, wr_cnt = 0, sel_cnt = 0, rply_cnt = 0;
    logic [5:0]  last_addr = '0;
    logic [1:0]  last_be = '0;
    logic [15:0] last_wd = '0;
    logic        last_trply = 1'b0;

    assign reg_rdata = regfile[reg_addr];

    always @(negedge qclk) begin
        last_trply <= TRPLY;
        if (TRPLY && !last_trply) rply_cnt <= rply_cnt + 1;
        if (selected) sel_cnt <= sel_cnt + 1;
        if (reg_rd) begin
            rd_cnt    <= rd_cnt + 1;
            last_addr <= reg_addr;
        end
        if (reg_wr) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= reg_addr;
            last_be   <= reg_be;
            last_wd   <= reg_wdata;
            if (reg_be[0]) regfile[reg_addr][7:0]  <= reg_wdata[7:0];
            if (reg_be[1]) regfile[reg_addr][15:8] <= reg_wdata[15:8];
        end
    end

    // Byte-addressed reference of what the register file should hold.
    logic [15:0] model_mem [NREGS] = '{default: 16'h0};

    task automatic model_apply(input int idx, input bit odd, input int kind, input logic [15:0] wd);
        if (kind == 1) model_mem[idx] = wd;
        else if (odd) model_mem[idx][15:8] = wd[15:8];
        else model_mem[idx][7:0] = wd[7:0];
    endtask

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    task automatic addr_phase(input logic [21:0] addr, input bit bs7, input bit wr);
        @(negedge qclk);
        RDAL = addr; RBS7 = bs7; RWTBT = wr;
        @(negedge qclk);
        RSYNC = 1'b1;
        repeat (3) @(negedge qclk);
        RBS7 = 1'b0; RWTBT = 1'b0; RDAL = 22'($urandom);
    endtask

    // dly: cycles after the strobe before reg_ready (0 = same cycle, <0 = never).
    task automatic data_phase(input bit is_rd, input bit bytew, input logic [15:0] wd, input int dly,
                              output bit rplied, output logic [15:0] rdata, output logic ad);
        bit seen;
        int since;
        seen = 1'b0; since = 0;
        rplied = 1'b0; rdata = '0; ad = 1'b0;
        if (is_rd) begin
            RDIN = 1'b1;
        end else begin
            RDAL = {6'b0, wd}; RWTBT = bytew; RDOUT = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge qclk);
            if (TRPLY) begin
                rplied = 1'b1; rdata = TDAL; ad = assert_data;
                break;
            end
            if (reg_rd || reg_wr) begin
                seen = 1'b1; since = 0;
            end else if (seen) begin
                since++;
            end
            reg_ready = (dly >= 0) && seen && (since == dly);
        end
        reg_ready = 1'b0;
    endtask

    task automatic end_data(output int drop);
        RDIN = 1'b0; RDOUT = 1'b0; RWTBT = 1'b0;
        drop = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge qclk);
            if (!TRPLY && !assert_data) begin
                drop = i;
                break;
            end
        end
    endtask

    task automatic end_cycle();
        RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; RWTBT = 1'b0;
        repeat (4) @(negedge qclk);
    endtask

    // kind: 0 DATI, 1 DATO, 2 DATOB.
    task automatic do_xfer(input string tag, input logic [21:0] addr, input bit bs7, input int kind,
                           input logic [15:0] wd, input int dly, input bit e_hit,
                           input logic [5:0] e_idx, input logic [1:0] e_be, input logic [15:0] e_data);
        int rd0, wr0, sel0, drop;
        bit rp;
        logic [15:0] rdat;
        logic ad;
        rd0 = rd_cnt; wr0 = wr_cnt; sel0 = sel_cnt;
        addr_phase(addr, bs7, kind != 0);
        data_phase(kind == 0, kind == 2, wd, dly, rp, rdat, ad);
        end_data(drop);
        end_cycle();
        check($sformatf("%s rply", tag), rp, e_hit);
        check($sformatf("%s selected", tag), (sel_cnt - sel0) > 0, e_hit);
        check($sformatf("%s rd strobes", tag), rd_cnt - rd0, (kind == 0) ? e_hit : 0);
        check($sformatf("%s wr strobes", tag), wr_cnt - wr0, (kind != 0) ? e_hit : 0);
        if (e_hit) begin
            check($sformatf("%s reg_addr", tag), last_addr, e_idx);
            check($sformatf("%s rply drop", tag), (drop >= 1) && (drop <= 3), 1);
            if (kind == 0) begin
                check($sformatf("%s TDAL", tag), rdat, e_data);
                check($sformatf("%s assert_data", tag), ad, 1);
            end else begin
                check($sformatf("%s reg_be", tag), last_be, e_be);
                check($sformatf("%s reg_wdata", tag), last_wd, e_data);
                check($sformatf("%s assert_data", tag), ad, 0);
            end
        end
        check($sformatf("%s idle after", tag), {TRPLY, assert_data, selected}, 0);
    endtask

    typedef struct {
        logic [21:0] addr;
        bit          bs7;
        int          kind;
        logic [15:0] wd;
        int          dly;
        bit          hit;
        logic [5:0]  idx;
        logic [1:0]  be;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int drop, rd0, wr0, rp0;
        bit rp;
        logic [15:0] rdat;
        logic ad;

        reset_n = 1'b0; RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; RWTBT = 1'b0;
        RBS7 = 1'b0; RINIT = 1'b0; RDAL = '0; reg_ready = 1'b0;
        repeat (3) @(negedge qclk);
        check("reset ctl outputs", {TRPLY, assert_data, reg_rd, reg_wr, selected, reg_be, reg_addr}, 0);
        check("reset data outputs", {TDAL, reg_wdata}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge qclk);

        vecs[0]  = '{22'o17777722, 1'b1, 1, 16'o123456, 0, 1'b1, 6'd1, 2'b11, 16'o123456};
        vecs[1]  = '{22'o17777722, 1'b1, 0, 16'o0,      0, 1'b1, 6'd1, 2'b00, 16'o123456};
        vecs[2]  = '{22'o17777725, 1'b1, 2, 16'o177400, 1, 1'b1, 6'd2, 2'b10, 16'o177400};
        vecs[3]  = '{22'o17777724, 1'b1, 2, 16'o000377, 2, 1'b1, 6'd2, 2'b01, 16'o000377};
        vecs[4]  = '{22'o17777724, 1'b1, 0, 16'o0,      3, 1'b1, 6'd2, 2'b00, 16'o177777};
        vecs[5]  = '{22'o17777700, 1'b1, 0, 16'o0,      0, 1'b0, 6'd0, 2'b00, 16'o0};
        vecs[6]  = '{22'o17777722, 1'b0, 0, 16'o0,      0, 1'b0, 6'd0, 2'b00, 16'o0};
        vecs[7]  = '{22'o17777736, 1'b1, 1, 16'o071234, 4, 1'b1, 6'd7, 2'b11, 16'o071234};
        vecs[8]  = '{22'o17777740, 1'b1, 1, 16'o055555, 0, 1'b0, 6'd0, 2'b00, 16'o0};
        vecs[9]  = '{22'o00017736, 1'b1, 0, 16'o0,      1, 1'b1, 6'd7, 2'b00, 16'o071234};
        vecs[10] = '{22'o17777716, 1'b1, 1, 16'o011111, 0, 1'b0, 6'd0, 2'b00, 16'o0};

        for (int i = 0; i < 11; i++) begin
            do_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].bs7, vecs[i].kind, vecs[i].wd,
                    vecs[i].dly, vecs[i].hit, vecs[i].idx, vecs[i].be, vecs[i].data);
            if (vecs[i].hit && vecs[i].kind != 0)
                model_apply(int'(vecs[i].idx), vecs[i].addr[0], vecs[i].kind, vecs[i].wd);
        end

        for (int n = 0; n < 48; n++) begin
            int off, kind, a13, idx, dly;
            bit bs7, hit;
            logic [21:0] addr;
            logic [15:0] wd, exp_d;
            logic [1:0] be;
            off  = int'($urandom_range(0, 2 * NREGS + 7)) - 4;
            kind = int'($urandom_range(0, 2));
            if (kind == 1) off = off & ~1;
            a13  = BASE + off;
            bs7  = ($urandom_range(0, 7) != 0);
            addr = {9'($urandom), 13'(a13)};
            hit  = bs7 && (off >= 0) && (off < 2 * NREGS);
            idx  = hit ? off / 2 : 0;
            be   = (kind == 2) ? (((off % 2) != 0) ? 2'b10 : 2'b01) : 2'b11;
            wd   = 16'($urandom);
            dly  = int'($urandom_range(0, 5));
            exp_d = (kind == 0) ? model_mem[idx] : wd;
            do_xfer($sformatf("rand%0d", n), addr, bs7, kind, wd, dly, hit, 6'(idx), be, exp_d);
            if (hit && kind != 0) model_apply(idx, (off % 2) != 0, kind, wd);
        end

        // DATIO: read then write of the same register within one SYNC.
        rd0 = rd_cnt; wr0 = wr_cnt; rp0 = rply_cnt;
        addr_phase(22'o17777720, 1'b1, 1'b0);
        data_phase(1'b1, 1'b0, 16'o0, 0, rp, rdat, ad);
        check("datio read rply", rp, 1);
        check("datio read data", rdat, model_mem[0]);
        end_data(drop);
        check("datio selected mid", selected, 1);
        data_phase(1'b0, 1'b0, 16'o052525, 1, rp, rdat, ad);
        check("datio write rply", rp, 1);
        check("datio selected write", selected, 1);
        end_data(drop);
        end_cycle();
        check("datio rd strobes", rd_cnt - rd0, 1);
        check("datio wr strobes", wr_cnt - wr0, 1);
        check("datio rply pulses", rply_cnt - rp0, 2);
        do_xfer("datio readback", 22'o17777720, 1'b1, 0, 16'o0, 0, 1'b1, 6'd0, 2'b00, 16'o052525);

        // Ready on the last allowed cycle is still honoured.
        addr_phase(22'o17777722, 1'b1, 1'b0);
        data_phase(1'b1, 1'b0, 16'o0, RDY_TMO - 1, rp, rdat, ad);
        check("late ready rply", rp, 1);
        check("late ready data", rdat, model_mem[1]);
        end_data(drop);
        end_cycle();

        // One cycle later the slave has given up; the late ready must be ignored.
        addr_phase(22'o17777722, 1'b1, 1'b0);
        data_phase(1'b1, 1'b0, 16'o0, RDY_TMO, rp, rdat, ad);
        check("timeout no rply", rp, 0);
        RINIT = 1'b1;
        repeat (4) @(negedge qclk);
        check("init clears", {TRPLY, assert_data, selected, reg_rd, reg_wr}, 0);
        RINIT = 1'b0;
        end_data(drop);
        end_cycle();
        do_xfer("after init", 22'o17777736, 1'b1, 0, 16'o0, 2, 1'b1, 6'd7, 2'b00, model_mem[7]);

        // INIT while RPLY is being held.
        addr_phase(22'o17777722, 1'b1, 1'b0);
        data_phase(1'b1, 1'b0, 16'o0, 0, rp, rdat, ad);
        check("init rdend rply", rp, 1);
        RINIT = 1'b1;
        repeat (3) @(negedge qclk);
        check("init rdend drop", {TRPLY, assert_data, selected}, 0);
        RINIT = 1'b0;
        end_data(drop);
        end_cycle();

        // Async reset while RPLY is being held.
        addr_phase(22'o17777722, 1'b1, 1'b0);
        data_phase(1'b1, 1'b0, 16'o0, 0, rp, rdat, ad);
        check("reset rdend rply", rp, 1);
        #5 reset_n = 1'b0;
        #1 check("reset rdend drop", {TRPLY, assert_data, selected}, 0);
        RDIN = 1'b0; RSYNC = 1'b0;
        repeat (3) @(negedge qclk);
        reset_n = 1'b1;
        repeat (2) @(negedge qclk);
        do_xfer("after reset", 22'o17777722, 1'b1, 0, 16'o0, 1, 1'b1, 6'd1, 2'b00, model_mem[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
